alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Two-stage pipelined issue/writeback wrapper placed directly in front of and behind the 32-bit ripple ALU. It accepts operand pairs with MIPS-style ALUOp/funct codes, decodes them into the ALU's 4-bit control word, and holds the operands stable in a register while the combinational ALU evaluates. It then captures result, zero, cout and overflow into an output register with a valid/ready handshake toward writeback.

## Interface
- TAG_W, 5, width of the pass-through destination tag (register index)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept this cycle
- in_src1, in_src2  in  32  operands
- in_aluop  in  2  00 add, 01 sub, 10 use funct, 11 slt
- in_funct  in  6  R-type funct (used only when aluop=10)
- in_tag  in  TAG_W  destination tag
- alu_src1, alu_src2  out  32  to ALU, driven from S1 register
- alu_ctrl  out  4  to ALU, decoded control word from S1
- alu_result  in  32  from ALU
- alu_zero, alu_cout, alu_overflow  in  1  from ALU
- out_valid  out  1  S2 holds a result
- out_ready  in  1  writeback accepts
- out_result  out  32; out_zero, out_cout, out_ovf  out  1; out_tag  out  TAG_W
- out_we  out  1  result may be written to the register file
- out_illegal  out  1  funct not recognised
- out_trap  out  1  overflow trap (see Configuration)

## Operation
- Decode (combinational, at input): aluop 00→0010, 01→0110, 11→0111. aluop 10 uses funct: 0x20→0010, 0x22→0110, 0x24→0000, 0x25→0001, 0x27→1100, 0x2A→0111. Any other funct→0000 with illegal=1.
- The decoded ctrl, the illegal bit and an is_addsub bit (ctrl 0010/0110 with aluop=10) are registered in S1 together with the operands and tag.
- The S1 fields drive alu_src1/alu_src2/alu_ctrl continuously. When S1 is empty these outputs hold their last values.
- S2 captures alu_* flags, tag, illegal and the trap decision.
- out_we = out_valid & ~out_illegal & ~out_trap.
- Flow control:
  - s2_free = ~s2_valid | out_ready.
  - S1 advances into S2 when s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free.
  - Accept on in_valid & in_ready.
- Simultaneous accept and advance in the same cycle is legal; S1 reloads from the new request.
- Outputs are stable while out_valid & ~out_ready. Verify that no field changes in that condition.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, in_ready=1, all data registers and flags 0, alu_ctrl=0000, out_trap=0, trap sticky=0.
- Reset has priority over any handshake in the same cycle. In-flight entries are dropped and not replayed.

## Timing
- Request accepted at edge k is in S1 during cycle k+1; the ALU evaluates within that cycle.
- S2 captures at edge k+1; out_valid is high in cycle k+2. Latency is 2 cycles.
- Throughput is 1 op/cycle with out_ready held high.
- in_ready is combinational from out_ready (no skid buffer). With out_ready low and both stages full, in_ready=0.
- The ALU path (32-bit ripple) must close within one clk period between the S1 and S2 registers.

## Configuration
- ALU_ISSUE_OVF_TRAP_EN defined:
  - out_trap = is_addsub & alu_overflow, registered into S2.
  - A sticky trap_seen output (1 bit, extra port) sets on any trapped op leaving S2. It clears only on rst.
- Not defined:
  - out_trap is tied to 0 and trap_seen is absent.
  - Overflowing add/sub writes normally (out_we=1).
- Overflow from aluop 00/01/11 never traps in either build.

## Structure
- Shared package alu_pkg:
  - ALU control constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100.
  - ALUOp and funct constants.
  - A packed s1 entry typedef.
- One sub-module alu_ctrl_dec: purely combinational decode of (aluop, funct) → (ctrl, illegal, is_addsub).
- The pipeline registers live in alu_issue_stage.

## Test plan
- After reset, check all outputs are 0 and in_ready=1. Then send add 5+7 (aluop=10, funct 0x20, tag 3) → out_result=12, out_tag=3, out_we=1, out_valid exactly 2 cycles after accept.
- Send sub 3−3 (aluop=01) → alu_ctrl=0110, out_result=0, out_zero=1.
- Send funct 0x2A with src1=0xFFFFFFFF, src2=1 → out_result=1. Send funct 0x3F → out_illegal=1, out_we=0.
- Send add 0x7FFFFFFF+1 (funct 0x20) → out_ovf=1. With the macro: out_trap=1, out_we=0, trap_seen=1. Without the macro: out_we=1.
- Back-to-back stream of 8 ops, with out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - No op is lost or duplicated; tags appear in order.
  - Outputs hold steady while stalled.
- Assert rst with both stages full → the next cycle out_valid=0 and in_ready=1, and no result from the dropped ops appears later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the S1 pipeline entry used by the issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Everything S1 hands the ALU plus the decode flags that ride along to S2.
    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic        illegal;
        logic        is_addsub;
    } s1_entry_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational MIPS ALUOp/funct decode into the 4-bit ALU control word.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       illegal,
    output logic       is_addsub
);

    always_comb begin
        ctrl      = ALU_AND;
        illegal   = 1'b0;
        is_addsub = 1'b0;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_SLT: ctrl = ALU_SLT;
            default: begin
                case (funct)
                    FUNCT_ADD: begin ctrl = ALU_ADD; is_addsub = 1'b1; end
                    FUNCT_SUB: begin ctrl = ALU_SUB; is_addsub = 1'b1; end
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback wrapper around an external combinational ALU.
// Optional overflow trap and sticky trap_seen port: define ALU_ISSUE_OVF_TRAP_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_we,
    output logic             out_illegal,
    output logic             out_trap
`ifdef ALU_ISSUE_OVF_TRAP_EN
    , output logic           trap_seen
`endif
);

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic             dec_addsub;

    s1_entry_t        s1_q;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_valid;

    logic             s2_valid;
    logic [31:0]      s2_result;
    logic             s2_zero;
    logic             s2_cout;
    logic             s2_ovf;
    logic             s2_illegal;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_free;
    logic             advance;
    logic             accept;

    alu_ctrl_dec u_dec (
        .aluop     (in_aluop),
        .funct     (in_funct),
        .ctrl      (dec_ctrl),
        .illegal   (dec_illegal),
        .is_addsub (dec_addsub)
    );

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; a producer holds valid and its payload steady until that edge.
    // in_ready looks straight through to out_ready, so a drain frees S1 in the
    // same cycle (no skid buffer).
    assign s2_free  = ~s2_valid | out_ready;
    assign advance  = s1_valid & s2_free;
    assign in_ready = ~s1_valid | s2_free;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
        end else begin
            if (accept) begin
                s1_q.src1      <= in_src1;
                s1_q.src2      <= in_src2;
                s1_q.ctrl      <= dec_ctrl;
                s1_q.illegal   <= dec_illegal;
                s1_q.is_addsub <= dec_addsub;
                s1_tag         <= in_tag;
                s1_valid       <= 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S1 data is left untouched when empty, so the ALU inputs hold their last values.
    assign alu_src1 = s1_q.src1;
    assign alu_src2 = s1_q.src2;
    assign alu_ctrl = s1_q.ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_cout    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else begin
            if (advance) begin
                s2_result  <= alu_result;
                s2_zero    <= alu_zero;
                s2_cout    <= alu_cout;
                s2_ovf     <= alu_overflow;
                s2_illegal <= s1_q.illegal;
                s2_tag     <= s1_tag;
                s2_valid   <= 1'b1;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic s2_trap;

    // Only R-type add/sub trap; aluop-driven arithmetic (address calc, branches) never does.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_trap   <= 1'b0;
            trap_seen <= 1'b0;
        end else begin
            if (advance) begin
                s2_trap <= s1_q.is_addsub & alu_overflow;
            end
            if (s2_valid & out_ready & s2_trap) begin
                trap_seen <= 1'b1;
            end
        end
    end

    assign out_trap = s2_trap;
`else
    logic unused_is_addsub;
    assign unused_is_addsub = s1_q.is_addsub;
    assign out_trap         = 1'b0;
`endif

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_zero    = s2_zero;
    assign out_cout    = s2_cout;
    assign out_ovf     = s2_ovf;
    assign out_tag     = s2_tag;
    assign out_illegal = s2_illegal;
    assign out_we      = s2_valid & ~s2_illegal & ~out_trap;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, queue-based reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_alu_issue_stage;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_cout;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic             out_we;
    logic             out_illegal;
    logic             out_trap;
`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic             trap_seen;
`endif

    alu_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .in_aluop     (in_aluop),
        .in_funct     (in_funct),
        .in_tag       (in_tag),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_cout     (out_cout),
        .out_ovf      (out_ovf),
        .out_tag      (out_tag),
        .out_we       (out_we),
        .out_illegal  (out_illegal),
        .out_trap     (out_trap)
`ifdef ALU_ISSUE_OVF_TRAP_EN
        , .trap_seen  (trap_seen)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural ALU (result, zero, cout, ovf) ----------------
    function automatic logic [34:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        logic [31:0] r;
        logic        co;
        logic        ov;
        r  = 32'd0;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[31:0];
                co  = sum[32];
                ov  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                co  = sum[32];
                ov  = (a[31] != b[31]) && (sum[31] != a[31]);
                r   = (c == 4'b0110) ? sum[31:0] : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            end
            default: r = 32'd0;
        endcase
        return {r, (r == 32'd0), co, ov};
    endfunction

    always_comb {alu_result, alu_zero, alu_cout, alu_overflow} = alu_fn(alu_ctrl, alu_src1, alu_src2);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [3:0]       ctrl;
        logic [31:0]      result;
        logic             zero;
        logic             cout;
        logic             ovf;
        logic             illegal;
        logic             trap;
        logic             we;
        logic [TAG_W-1:0] tag;
        logic             vis;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    logic             m_trap_seen;
    logic             started = 1'b0;

    // {ctrl, illegal, is_addsub}
    function automatic logic [5:0] dec_ref(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return {4'b0010, 2'b00};
        if (op == 2'd1) return {4'b0110, 2'b00};
        if (op == 2'd3) return {4'b0111, 2'b00};
        case (f)
            6'h20: return {4'b0010, 2'b01};
            6'h22: return {4'b0110, 2'b01};
            6'h24: return {4'b0000, 2'b00};
            6'h25: return {4'b0001, 2'b00};
            6'h27: return {4'b1100, 2'b00};
            6'h2A: return {4'b0111, 2'b00};
            default: return {4'b0000, 2'b10};
        endcase
    endfunction

    function automatic exp_t make_entry(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic [5:0] f,
                                        input logic [TAG_W-1:0] t);
        exp_t        e;
        logic [5:0]  d;
        logic [34:0] r;
        d = dec_ref(op, f);
        r = alu_fn(d[5:2], a, b);
        e.src1    = a;
        e.src2    = b;
        e.ctrl    = d[5:2];
        e.result  = r[34:3];
        e.zero    = r[2];
        e.cout    = r[1];
        e.ovf     = r[0];
        e.illegal = d[1];
`ifdef ALU_ISSUE_OVF_TRAP_EN
        e.trap    = d[0] & r[0];
`else
        e.trap    = 1'b0;
`endif
        e.we      = !e.illegal && !e.trap;
        e.tag     = t;
        e.vis     = 1'b0;
        return e;
    endfunction

    // Entries in flight, oldest first; vis marks the one sitting in the output register.
    always @(posedge clk) begin
        exp_t h;
        logic acc;
        if (rst) begin
            exp_q.delete();
            m_trap_seen = 1'b0;
            started     = 1'b1;
        end else if (started) begin
            acc = in_valid && !(exp_q.size() == 2 && !out_ready);
            if (exp_q.size() > 0 && exp_q[0][0] && out_ready) begin
                h = exp_t'(exp_q[0]);
                if (h.trap) m_trap_seen = 1'b1;
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && !exp_q[0][0]) exp_q[0][0] = 1'b1;
            if (acc) exp_q.push_back(make_entry(in_src1, in_src2, in_aluop, in_funct, in_tag));
        end
    end

    // ---------------- compare process ----------------
    logic             stall_prev = 1'b0;
    logic [41:0]      snap;
    logic             saw_ready_low;
    logic [TAG_W-1:0] obs_q[$];

    always @(negedge clk) begin
        exp_t h;
        logic exp_vld;
        if (started) begin
            exp_vld = exp_q.size() > 0 && exp_q[0][0];
            chk("out_valid", out_valid, exp_vld);
            chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
            if (exp_vld) begin
                h = exp_t'(exp_q[0]);
                chk("out_result", out_result, h.result);
                chk("out_zero", out_zero, h.zero);
                chk("out_cout", out_cout, h.cout);
                chk("out_ovf", out_ovf, h.ovf);
                chk("out_tag", out_tag, h.tag);
                chk("out_illegal", out_illegal, h.illegal);
                chk("out_trap", out_trap, h.trap);
                chk("out_we", out_we, h.we);
            end else begin
                chk("out_we_idle", out_we, 1'b0);
            end
            if (exp_q.size() > 0 && !exp_q[exp_q.size()-1][0]) begin
                h = exp_t'(exp_q[exp_q.size()-1]);
                chk("alu_src1", alu_src1, h.src1);
                chk("alu_src2", alu_src2, h.src2);
                chk("alu_ctrl", alu_ctrl, h.ctrl);
            end
`ifdef ALU_ISSUE_OVF_TRAP_EN
            chk("trap_seen", trap_seen, m_trap_seen);
`endif
            if (stall_prev)
                chk("stall_hold", {out_valid, out_result, out_zero, out_cout, out_ovf,
                                   out_tag, out_illegal, out_trap, out_we}, snap);
            stall_prev = out_valid && !out_ready && !rst;
            snap = {out_valid, out_result, out_zero, out_cout, out_ovf,
                    out_tag, out_illegal, out_trap, out_we};
            if (!in_ready) saw_ready_low = 1'b1;
            if (out_valid && out_ready && !rst) obs_q.push_back(out_tag);
        end
    end

    // ---------------- driver tasks (start and end #1 after a rising edge) ----------------
    task automatic drive_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                             input logic [5:0] f, input logic [TAG_W-1:0] t);
        logic got;
        in_valid = 1'b1;
        in_src1  = a;
        in_src2  = b;
        in_aluop = op;
        in_funct = f;
        in_tag   = t;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("accept_timeout", got, 1'b1);
        if (got) begin @(posedge clk); #1; end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [5:0] f, input logic [TAG_W-1:0] t,
                         input logic [3:0] e_ctrl, input logic [31:0] e_res, input logic e_zero,
                         input logic e_ovf, input logic e_ill, input logic e_we, input logic e_trap);
        int n;
        logic seen;
        drive_one(a, b, op, f, t);
        in_valid = 1'b0;
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (n == 1) chk("lit_alu_ctrl", alu_ctrl, e_ctrl);
            if (out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("lit_latency", n, 2);
        chk("lit_result", out_result, e_res);
        chk("lit_zero", out_zero, e_zero);
        chk("lit_ovf", out_ovf, e_ovf);
        chk("lit_tag", out_tag, t);
        chk("lit_illegal", out_illegal, e_ill);
        chk("lit_we", out_we, e_we);
        chk("lit_trap", out_trap, e_trap);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] funct_tbl[0:6];

    // ---------------- main sequence ----------------
    initial begin
        logic hold;
        int   bad;
        funct_tbl[0] = 6'h20; funct_tbl[1] = 6'h22; funct_tbl[2] = 6'h24;
        funct_tbl[3] = 6'h25; funct_tbl[4] = 6'h27; funct_tbl[5] = 6'h2A;
        funct_tbl[6] = 6'h3F;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_src1 = '0; in_src2 = '0; in_aluop = '0; in_funct = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {out_zero, out_cout, out_ovf, out_we, out_illegal, out_trap}, 6'd0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_alu_ctrl", alu_ctrl, 4'b0000);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        chk("rst_trap_seen", trap_seen, 1'b0);
`endif
        @(posedge clk); #1;

        do_op(32'd5, 32'd7, 2'b10, 6'h20, 5'd3, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(32'd3, 32'd3, 2'b01, 6'h00, 5'd4, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd1, 2'b10, 6'h2A, 5'd5, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(32'd9, 32'd4, 2'b10, 6'h3F, 5'd6, 4'b0000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'd1, 2'b00, 6'h00, 5'd8, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        do_op(32'h7FFF_FFFF, 32'd1, 2'b10, 6'h20, 5'd7, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("lit_trap_seen", trap_seen, 1'b1);
        @(posedge clk); #1;
`else
        do_op(32'h7FFF_FFFF, 32'd1, 2'b10, 6'h20, 5'd7, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

        // back-to-back stream with a 3-cycle writeback stall
        obs_q.delete();
        saw_ready_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_one(rand_operand(), rand_operand(), 2'b10, funct_tbl[$urandom_range(0, 5)], 5'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        chk("stream_stall_seen", saw_ready_low, 1'b1);
        chk("stream_count", obs_q.size(), 8);
        bad = 0;
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            if (obs_q[i] != 5'(i)) bad++;
        chk("stream_order", bad, 0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hold = in_valid && !in_ready;
            @(posedge clk); #1;
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_src1  = rand_operand();
                in_src2  = rand_operand();
                in_aluop = 2'($urandom_range(0, 3));
                in_funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funct_tbl[$urandom_range(0, 6)];
                in_tag   = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // reset with both stages full drops the in-flight pair
        out_ready = 1'b0;
        drive_one(32'd1, 32'd2, 2'b00, 6'h00, 5'd10);
        drive_one(32'd3, 32'd4, 2'b00, 6'h00, 5'd11);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_full_out_valid", out_valid, 1'b0);
        chk("rst_full_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        obs_q.delete();
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_dropped", obs_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
